// File: rtl/button_step_ctrl.sv
// button_step_ctrl
//   Turns one bouncing board button into a processor clock-enable.
//   A short press issues a single processor step on release; holding the
//   button for LONG_PRESS_CYCLES arms free-run mode, which starts on release
//   and stops at the next press.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   button     raw button, asynchronous to clk and bouncing
//   cpu_en     processor clock-enable, one assertion = one processor cycle
//   run_mode   1 while free-running (RUN_ARM or RUN), 0 in single-step
//   pressed    debounced button level, 1 = pressed regardless of polarity
//   step_count number of cpu_en assertions since reset (wraps at 16 bits)
module button_step_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int RUN_DIV           = 1,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        button,
  output logic        cpu_en,
  output logic        run_mode,
  output logic        pressed,
  output logic [15:0] step_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int PS_W   = $clog2(RUN_DIV + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(RUN_DIV - 1);
  localparam logic [PS_W-1:0]   PS_ONE    = PS_W'(1);

  // Raw button level when nobody is touching it.
  localparam logic IDLE_LVL = logic'(BUTTON_ACTIVE_LOW);

  typedef enum logic [2:0] {STEP, HELD, RUN_ARM, RUN, STOP_WAIT} state_t;

  logic              btn_p0, btn_p1;
  logic              s;
  logic [DB_W-1:0]   db_cnt;
  logic              pressed_d;
  logic              db_flip, rise_next, press_ev, rel_ev;
  state_t            state, state_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic [PS_W-1:0]   presc, presc_next;
  logic              step_pulse, cpu_en_next, run_mode_next;

  // ---- stage p0/p1: two-flop synchronizer, reset to the released level ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0 <= IDLE_LVL;
      btn_p1 <= IDLE_LVL;
    end else begin
      btn_p0 <= button;
      btn_p1 <= btn_p0;
    end
  end

  // Normalised sample: 1 = pressed.
  assign s = btn_p1 ^ IDLE_LVL;

  // ---- debounce: accept a change after DEBOUNCE_CYCLES differing samples ----
  assign db_flip   = (s != pressed) && (db_cnt == DB_LAST);
  // The press event will be seen next cycle; lets the registered cpu_en
  // be suppressed in the very cycle the press event lands.
  assign rise_next = db_flip && !pressed;
  assign press_ev  = pressed && !pressed_d;
  assign rel_ev    = !pressed && pressed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      pressed   <= 1'b0;
      pressed_d <= 1'b0;
    end else begin
      pressed_d <= pressed;
      if (s == pressed) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        pressed <= !pressed;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end
  end

  // ---- mode FSM: next state, hold counter, prescaler ----
  always_comb begin
    state_next = state;
    hold_next  = hold;
    presc_next = presc;
    step_pulse = 1'b0;
    case (state)
      STEP: begin
        if (press_ev) begin
          state_next = HELD;
          hold_next  = '0;
        end
      end
      HELD: begin
        if (rel_ev) begin
          if (hold < HOLD_LAST) begin
            state_next = STEP;
            step_pulse = 1'b1;
          end else begin
            // Released exactly as the long-press threshold was reached:
            // the hold already counts as long, so go straight to running.
            state_next = RUN;
            presc_next = '0;
          end
        end else if (hold >= HOLD_LAST) begin
          state_next = RUN_ARM;
        end else begin
          hold_next = hold + HOLD_ONE;
        end
      end
      RUN_ARM: begin
        if (rel_ev) begin
          state_next = RUN;
          presc_next = '0;
        end
      end
      RUN: begin
        if (press_ev) begin
          state_next = STOP_WAIT;
        end else begin
          presc_next = (presc == PS_LAST) ? '0 : presc + PS_ONE;
        end
      end
      STOP_WAIT: begin
        if (rel_ev) state_next = STEP;
      end
      default: state_next = STEP;
    endcase

    // Outputs are registered, so they are derived from the next-cycle view.
    cpu_en_next   = step_pulse ||
                    ((state_next == RUN) && (presc_next == PS_LAST) && !rise_next);
    run_mode_next = (state_next == RUN_ARM) || (state_next == RUN);
  end

  // ---- registered state and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STEP;
      hold       <= '0;
      presc      <= '0;
      cpu_en     <= 1'b0;
      run_mode   <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_next;
      hold       <= hold_next;
      presc      <= presc_next;
      cpu_en     <= cpu_en_next;
      run_mode   <= run_mode_next;
      step_count <= step_count + 16'(cpu_en);
    end
  end

endmodule
